// File: rtl/dat_xfer_sequencer.sv
// Multi-block SD DAT-line transfer sequencer around the serializer/deserializer wrappers.
// Optional feature: define DAT_BUSY_TIMEOUT_EN to apply the timeout to write busy as well as read start-bit wait.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for strobe_in; all outputs quiet
// WR_FETCH  | waiting for a FIFO word, pops it when available
// WR_LOAD   | one-cycle load pulse into the serializer
// WR_SEND   | serializer shifting the frame out, host drives DAT
// WR_BUSY   | card holds DAT0 low while programming
// GAP       | idle cycles between consecutive blocks
// RD_WAIT   | waiting for the card start bit on DAT0
// RD_RECV   | deserializer running, then push of the frame to the FIFO
// DONE      | transfer finished or timed out, waiting for ack_in

module dat_xfer_sequencer #(
   parameter int BLK_WIDTH  = 4,
   parameter int TOUT_WIDTH = 16,
   parameter int GAP_CYCLES = 2
) (
   input  logic                  sd_clock,
   input  logic                  reset,
   input  logic                  strobe_in,
   input  logic                  ack_in,
   input  logic                  idle_in,
   input  logic [TOUT_WIDTH-1:0] TIMEOUT_REG,
   input  logic [BLK_WIDTH-1:0]  blocks,
   input  logic                  writeRead,
   input  logic                  multiple,
   input  logic                  dat_in,
   input  logic                  fifo_ready,
   input  logic                  pts_complete,
   input  logic                  stp_complete,
   output logic                  pts_enable,
   output logic                  pts_load,
   output logic                  stp_enable,
   output logic                  fifo_read,
   output logic                  fifo_write,
   output logic                  dir_out,
   output logic [BLK_WIDTH-1:0]  blocks_done,
   output logic                  busy,
   output logic                  complete,
   output logic                  timeout
);

   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_WR_FETCH,
      S_WR_LOAD,
      S_WR_SEND,
      S_WR_BUSY,
      S_GAP,
      S_RD_WAIT,
      S_RD_RECV,
      S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic                  wr_q, wr_d;
   logic [BLK_WIDTH-1:0]  target_q, target_d;
   logic [BLK_WIDTH-1:0]  blocks_done_q, blocks_done_d;
   logic                  timeout_q, timeout_d;
   logic [TOUT_WIDTH-1:0] tout_q, tout_d;
   logic [GW-1:0]         gap_q, gap_d;
   logic                  pend_q, pend_d;

   logic                  blk_end;
   logic                  tout_hit;
   logic [BLK_WIDTH:0]    done_inc;

   assign done_inc = {1'b0, blocks_done_q} + 1'b1;
   assign tout_hit = (TIMEOUT_REG != '0) && (tout_q == TIMEOUT_REG);

   always_ff @(posedge sd_clock) begin
      if (reset) begin
         state_q       <= S_IDLE;
         wr_q          <= 1'b0;
         target_q      <= '0;
         blocks_done_q <= '0;
         timeout_q     <= 1'b0;
         tout_q        <= '0;
         gap_q         <= '0;
         pend_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         wr_q          <= wr_d;
         target_q      <= target_d;
         blocks_done_q <= blocks_done_d;
         timeout_q     <= timeout_d;
         tout_q        <= tout_d;
         gap_q         <= gap_d;
         pend_q        <= pend_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      wr_d          = wr_q;
      target_d      = target_q;
      blocks_done_d = blocks_done_q;
      timeout_d     = timeout_q;
      tout_d        = tout_q;
      gap_d         = gap_q;
      pend_d        = pend_q;
      blk_end       = 1'b0;
      fifo_read     = 1'b0;
      fifo_write    = 1'b0;

      // Abort has priority over every other event in the same cycle.
      if ((state_q != S_IDLE) && idle_in) begin
         state_d = S_IDLE;
         pend_d  = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (strobe_in && !idle_in) begin
                  wr_d          = writeRead;
                  target_d      = (!multiple || (blocks == '0)) ? BLK_WIDTH'(1) : blocks;
                  blocks_done_d = '0;
                  timeout_d     = 1'b0;
                  tout_d        = '0;
                  pend_d        = 1'b0;
                  state_d       = writeRead ? S_WR_FETCH : S_RD_WAIT;
               end
            end
            S_WR_FETCH: begin
               if (fifo_ready) begin
                  fifo_read = 1'b1;
                  state_d   = S_WR_LOAD;
               end
            end
            S_WR_LOAD: state_d = S_WR_SEND;
            S_WR_SEND: begin
               if (pts_complete) begin
                  tout_d  = '0;
                  state_d = S_WR_BUSY;
               end
            end
            S_WR_BUSY: begin
               if (dat_in)
                  blk_end = 1'b1;
`ifdef DAT_BUSY_TIMEOUT_EN
               else if (tout_hit) begin
                  timeout_d = 1'b1;
                  state_d   = S_DONE;
               end
`endif
               else
                  tout_d = tout_q + 1'b1;
            end
            S_RD_WAIT: begin
               // Start bit wins over a limit reached in the same cycle.
               if (!dat_in)
                  state_d = S_RD_RECV;
               else if (tout_hit) begin
                  timeout_d = 1'b1;
                  state_d   = S_DONE;
               end else
                  tout_d = tout_q + 1'b1;
            end
            S_RD_RECV: begin
               if ((stp_complete || pend_q) && fifo_ready) begin
                  fifo_write = 1'b1;
                  pend_d     = 1'b0;
                  blk_end    = 1'b1;
               end else if (stp_complete)
                  pend_d = 1'b1;
            end
            S_GAP: begin
               if (gap_q == '0) begin
                  tout_d  = '0;
                  state_d = wr_q ? S_WR_FETCH : S_RD_WAIT;
               end else
                  gap_d = gap_q - 1'b1;
            end
            S_DONE: begin
               if (ack_in)
                  state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase

         if (blk_end) begin
            if (!(&blocks_done_q))
               blocks_done_d = done_inc[BLK_WIDTH-1:0];
            if (done_inc == {1'b0, target_q})
               state_d = S_DONE;
            else begin
               gap_d   = GAP_LOAD;
               state_d = S_GAP;
            end
         end
      end
   end

   assign pts_enable  = (state_q == S_WR_LOAD) || (state_q == S_WR_SEND);
   assign pts_load    = (state_q == S_WR_LOAD);
   assign stp_enable  = (state_q == S_RD_RECV) && !pend_q;
   assign dir_out     = (state_q == S_WR_SEND);
   assign busy        = (state_q != S_IDLE);
   assign complete    = (state_q == S_DONE);
   assign blocks_done = blocks_done_q;
   assign timeout     = timeout_q;

endmodule

// File: tb/tb_dat_xfer_sequencer.sv
// Directed bench for dat_xfer_sequencer; honours DAT_BUSY_TIMEOUT_EN for the write-busy timeout case.

module tb_dat_xfer_sequencer;

   logic        sd_clock;
   logic        reset;
   logic        strobe_in, ack_in, idle_in;
   logic [15:0] TIMEOUT_REG;
   logic [3:0]  blocks;
   logic        writeRead, multiple, dat_in, fifo_ready;
   logic        pts_complete, stp_complete;
   logic        pts_enable, pts_load, stp_enable, fifo_read, fifo_write, dir_out;
   logic [3:0]  blocks_done;
   logic        busy, complete, timeout;

   int checks = 0;
   int failures = 0;
   int n_rd = 0, n_wr = 0, n_ld = 0, n_consec = 0;
   int base_rd, base_wr, base_ld;
   logic p_rd = 1'b0, p_wr = 1'b0, p_ld = 1'b0;

   dat_xfer_sequencer dut (
      .sd_clock     (sd_clock),
      .reset        (reset),
      .strobe_in    (strobe_in),
      .ack_in       (ack_in),
      .idle_in      (idle_in),
      .TIMEOUT_REG  (TIMEOUT_REG),
      .blocks       (blocks),
      .writeRead    (writeRead),
      .multiple     (multiple),
      .dat_in       (dat_in),
      .fifo_ready   (fifo_ready),
      .pts_complete (pts_complete),
      .stp_complete (stp_complete),
      .pts_enable   (pts_enable),
      .pts_load     (pts_load),
      .stp_enable   (stp_enable),
      .fifo_read    (fifo_read),
      .fifo_write   (fifo_write),
      .dir_out      (dir_out),
      .blocks_done  (blocks_done),
      .busy         (busy),
      .complete     (complete),
      .timeout      (timeout)
   );

   initial sd_clock = 1'b0;
   always #5 sd_clock = ~sd_clock;

   always @(negedge sd_clock) begin
      if (fifo_read === 1'b1) n_rd++;
      if (fifo_write === 1'b1) n_wr++;
      if (pts_load === 1'b1) n_ld++;
      if ((fifo_read === 1'b1 && p_rd) || (fifo_write === 1'b1 && p_wr) || (pts_load === 1'b1 && p_ld))
         n_consec++;
      p_rd = (fifo_read === 1'b1);
      p_wr = (fifo_write === 1'b1);
      p_ld = (pts_load === 1'b1);
   end

   task automatic tick();
      @(posedge sd_clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [12:0] outs();
      return {pts_enable, pts_load, stp_enable, fifo_read, fifo_write, dir_out,
              busy, complete, timeout, blocks_done};
   endfunction

   initial begin
      reset = 1'b1; strobe_in = 0; ack_in = 0; idle_in = 0; TIMEOUT_REG = 16'd0;
      blocks = 4'd0; writeRead = 0; multiple = 0; dat_in = 1; fifo_ready = 0;
      pts_complete = 0; stp_complete = 0;
      repeat (2) tick();
      reset = 1'b0;
      chk("reset_outs", 32'(outs()), 32'd0);

      // abort wins over start in IDLE
      strobe_in = 1; idle_in = 1;
      tick();
      strobe_in = 0; idle_in = 0;
      chk("idle_beats_strobe", 32'(busy), 32'd0);

      // single-block read, multiple=0 blocks=4
      writeRead = 0; multiple = 0; blocks = 4'd4; strobe_in = 1;
      tick();
      strobe_in = 0;
      chk("rd1_busy", 32'(busy), 32'd1);
      chk("rd1_dir", 32'(dir_out), 32'd0);
      repeat (8) tick();
      dat_in = 0;
      tick();
      dat_in = 1;
      chk("rd1_stp_en", 32'(stp_enable), 32'd1);
      base_wr = n_wr;
      repeat (49) tick();
      stp_complete = 1; fifo_ready = 1;
      #1;
      chk("rd1_fifo_write", 32'(fifo_write), 32'd1);
      tick();
      stp_complete = 0; fifo_ready = 0;
      chk("rd1_complete", 32'(complete), 32'd1);
      chk("rd1_blocks_done", 32'(blocks_done), 32'd1);
      chk("rd1_timeout", 32'(timeout), 32'd0);
      chk("rd1_stp_off", 32'(stp_enable), 32'd0);
      tick();
      chk("rd1_complete_hold", 32'(complete), 32'd1);
      ack_in = 1;
      tick();
      ack_in = 0;
      chk("rd1_idle", 32'({busy, complete}), 32'd0);
      chk("rd1_nwrites", 32'(n_wr - base_wr), 32'd1);

      // multi-block write, blocks=3
      base_rd = n_rd; base_ld = n_ld;
      writeRead = 1; multiple = 1; blocks = 4'd3; fifo_ready = 1; dat_in = 1; strobe_in = 1;
      tick();
      strobe_in = 0;
      for (int b = 1; b <= 3; b++) begin
         chk("wr_fetch_read", 32'(fifo_read), 32'd1);
         tick();
         chk("wr_load", 32'({pts_load, pts_enable, fifo_read}), 32'b110);
         tick();
         chk("wr_send", 32'({pts_load, pts_enable, dir_out}), 32'b011);
         pts_complete = 1;
         tick();
         pts_complete = 0;
         chk("wr_busy_dir", 32'({pts_enable, dir_out}), 32'd0);
         tick();
         chk("wr_blocks_done", 32'(blocks_done), 32'(b));
         if (b < 3) begin
            chk("wr_gap1", 32'({fifo_read, complete, busy}), 32'b001);
            tick();
            chk("wr_gap2", 32'({fifo_read, complete, busy}), 32'b001);
            tick();
         end else begin
            chk("wr_complete", 32'(complete), 32'd1);
         end
      end
      repeat (3) tick();
      chk("wr_complete_hold", 32'(complete), 32'd1);
      ack_in = 1;
      tick();
      ack_in = 0; fifo_ready = 0;
      chk("wr_idle", 32'(busy), 32'd0);
      chk("wr_nreads", 32'(n_rd - base_rd), 32'd3);
      chk("wr_nloads", 32'(n_ld - base_ld), 32'd3);

      // read timeout, limit 100
      TIMEOUT_REG = 16'd100; writeRead = 0; multiple = 0; dat_in = 1; strobe_in = 1;
      tick();
      strobe_in = 0;
      repeat (100) tick();
      chk("rto_before", 32'({timeout, complete}), 32'd0);
      tick();
      chk("rto_flag", 32'({timeout, complete}), 32'b11);
      chk("rto_blocks", 32'(blocks_done), 32'd0);
      ack_in = 1;
      tick();
      ack_in = 0;
      chk("rto_sticky", 32'({timeout, busy}), 32'b10);

      // start bit coincides with limit; blocks=0 means one block; FIFO-full stall
      TIMEOUT_REG = 16'd20; multiple = 1; blocks = 4'd0; strobe_in = 1;
      tick();
      strobe_in = 0;
      chk("tie_cleared", 32'(timeout), 32'd0);
      repeat (20) tick();
      dat_in = 0;
      tick();
      dat_in = 1;
      chk("tie_recv", 32'({stp_enable, timeout}), 32'b10);
      stp_complete = 1; fifo_ready = 0;
      #1;
      chk("stall_no_write", 32'(fifo_write), 32'd0);
      tick();
      stp_complete = 0;
      chk("stall_stp_off", 32'({stp_enable, busy}), 32'b01);
      tick();
      chk("stall_stp_off2", 32'({stp_enable, fifo_write}), 32'd0);
      fifo_ready = 1;
      #1;
      chk("stall_write", 32'(fifo_write), 32'd1);
      tick();
      fifo_ready = 0;
      chk("stall_done", 32'({complete, timeout, blocks_done}), 32'b10_0001);
      ack_in = 1;
      tick();
      ack_in = 0;

      // abort in WR_SEND of block 2
      TIMEOUT_REG = 16'd0; writeRead = 1; multiple = 1; blocks = 4'd3; fifo_ready = 1; strobe_in = 1;
      tick();
      strobe_in = 0;
      tick();
      tick();
      pts_complete = 1;
      tick();
      pts_complete = 0;
      repeat (3) tick();
      tick();
      tick();
      chk("abort_in_send", 32'({dir_out, blocks_done}), 32'b1_0001);
      idle_in = 1; pts_complete = 1;
      tick();
      idle_in = 0; pts_complete = 0; fifo_ready = 0;
      chk("abort_idle", 32'({busy, pts_enable, dir_out}), 32'd0);
      chk("abort_blocks", 32'(blocks_done), 32'd1);

      // reset during the second block of a read
      writeRead = 0; multiple = 1; blocks = 4'd2; strobe_in = 1;
      tick();
      strobe_in = 0; dat_in = 0;
      tick();
      dat_in = 1; stp_complete = 1; fifo_ready = 1;
      tick();
      stp_complete = 0; fifo_ready = 0;
      chk("rst_rd_gap", 32'({busy, blocks_done}), 32'b1_0001);
      tick();
      tick();
      dat_in = 0;
      tick();
      dat_in = 1;
      chk("rst_rd_recv", 32'(stp_enable), 32'd1);
      reset = 1;
      tick();
      reset = 0;
      chk("rst_mid_outs", 32'(outs()), 32'd0);

      // write with DAT0 held low in busy
      TIMEOUT_REG = 16'd100; writeRead = 1; multiple = 0; fifo_ready = 1; dat_in = 1; strobe_in = 1;
      tick();
      strobe_in = 0;
      tick();
      fifo_ready = 0;
      tick();
      pts_complete = 1; dat_in = 0;
      tick();
      pts_complete = 0;
`ifdef DAT_BUSY_TIMEOUT_EN
      repeat (100) tick();
      chk("wbusy_before", 32'({timeout, complete}), 32'd0);
      tick();
      chk("wbusy_timeout", 32'({timeout, complete, blocks_done}), 32'b11_0000);
`else
      repeat (500) tick();
      chk("wbusy_wait", 32'({timeout, busy, complete}), 32'b010);
      dat_in = 1;
      tick();
      chk("wbusy_done", 32'({timeout, complete, blocks_done}), 32'b01_0001);
`endif
      dat_in = 1; ack_in = 1;
      tick();
      ack_in = 0;
      chk("final_idle", 32'(busy), 32'd0);
      chk("single_cycle_pulses", 32'(n_consec), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
